// File: rtl/active_list_commit_pkg.sv
// Shared core constants and types for the active list: sizes, writeback flag
// positions and the per-entry status record.
package active_list_commit_pkg;
   localparam int AL_SIZE  = 32;
   localparam int AL_LOG   = 5;
   localparam int WB_PORTS = 4;
   localparam int WB_FLAGS = 4;

   localparam int FLAG_EXCEPTION   = 0;
   localparam int FLAG_MISPREDICT  = 1;
   localparam int FLAG_CONDITIONAL = 2;

   typedef logic [AL_LOG-1:0] al_id_t;
   typedef logic [AL_LOG:0]   al_cnt_t;

   typedef struct packed {
      logic valid;
      logic done;
      logic exception;
      logic violation;
   } al_entry_t;

   function automatic logic entry_commits(al_entry_t e);
      return e.valid & e.done & ~e.exception & ~e.violation;
   endfunction

   function automatic logic entry_faults(al_entry_t e);
      return e.valid & e.done & (e.exception | e.violation);
   endfunction
endpackage

// File: rtl/active_list_commit_if.sv
// Dispatch, writeback, violation and commit/recovery signals of the active list.
interface active_list_commit_if;
   import active_list_commit_pkg::*;

   logic [1:0]                   dispatchValid_i;
   al_id_t                       alTail_o;
   logic                         alFull_o;
   logic                         writebkValid0_i;
   logic                         writebkValid1_i;
   logic                         writebkValid2_i;
   logic                         writebkValid3_i;
   logic [AL_LOG+WB_FLAGS-1:0]   ctrlFU0_i;
   logic [AL_LOG+WB_FLAGS-1:0]   ctrlFU1_i;
   logic [AL_LOG+WB_FLAGS-1:0]   ctrlFU2_i;
   logic [AL_LOG+WB_FLAGS-1:0]   ctrlFU3_i;
   logic [AL_LOG:0]              ldViolationPacket_i;
   logic                         commitValid0_o;
   logic                         commitValid1_o;
   al_id_t                       commitAlId0_o;
   al_id_t                       commitAlId1_o;
   logic                         flush_o;
   al_id_t                       flushAlId_o;
   al_cnt_t                      alCount_o;

   modport master (
      output dispatchValid_i, writebkValid0_i, writebkValid1_i, writebkValid2_i,
             writebkValid3_i, ctrlFU0_i, ctrlFU1_i, ctrlFU2_i, ctrlFU3_i,
             ldViolationPacket_i,
      input  alTail_o, alFull_o, commitValid0_o, commitValid1_o, commitAlId0_o,
             commitAlId1_o, flush_o, flushAlId_o, alCount_o
   );

   modport slave (
      input  dispatchValid_i, writebkValid0_i, writebkValid1_i, writebkValid2_i,
             writebkValid3_i, ctrlFU0_i, ctrlFU1_i, ctrlFU2_i, ctrlFU3_i,
             ldViolationPacket_i,
      output alTail_o, alFull_o, commitValid0_o, commitValid1_o, commitAlId0_o,
             commitAlId1_o, flush_o, flushAlId_o, alCount_o
   );
endinterface

// File: rtl/active_list_commit_al_status_bank.sv
// Per-entry valid/done/exception/violation bits of the active list, with
// allocate, retire, writeback and violation write ports and head/head+1 reads.
module al_status_bank
   import active_list_commit_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear_all,
   input  logic [1:0]                  alloc_en,
   input  logic [1:0][AL_LOG-1:0]      alloc_id,
   input  logic [1:0]                  retire_en,
   input  logic [1:0][AL_LOG-1:0]      retire_id,
   input  logic [WB_PORTS-1:0]         wb_en,
   input  logic [WB_PORTS-1:0][AL_LOG-1:0] wb_id,
   input  logic [WB_PORTS-1:0]         wb_exc,
   input  logic                        viol_en,
   input  al_id_t                      viol_id,
   input  al_id_t                      head_id,
   output al_entry_t                   head_entry,
   output al_entry_t                   head_next_entry
);
   al_entry_t bank [AL_SIZE];

   // Allocation is applied last so a freshly allocated entry always starts clean.
   always_ff @(posedge clk) begin
      for (int e = 0; e < AL_SIZE; e++) begin
         if (reset || clear_all) begin
            bank[e] <= '0;
         end else begin
            for (int r = 0; r < 2; r++)
               if (retire_en[r] && retire_id[r] == al_id_t'(e))
                  bank[e].valid <= 1'b0;
            for (int p = 0; p < WB_PORTS; p++)
               if (wb_en[p] && wb_id[p] == al_id_t'(e) && bank[e].valid) begin
                  bank[e].done <= 1'b1;
                  if (wb_exc[p])
                     bank[e].exception <= 1'b1;
               end
            if (viol_en && viol_id == al_id_t'(e) && bank[e].valid)
               bank[e].violation <= 1'b1;
            for (int s = 0; s < 2; s++)
               if (alloc_en[s] && alloc_id[s] == al_id_t'(e))
                  bank[e] <= '{valid: 1'b1, done: 1'b0, exception: 1'b0, violation: 1'b0};
         end
      end
   end

   assign head_entry      = bank[head_id];
   assign head_next_entry = bank[al_id_t'(head_id + al_id_t'(1))];
endmodule

// File: rtl/active_list_commit.sv
// In-order commit window: allocates ids at dispatch, collects writeback status,
// retires up to two entries per cycle and raises a flush on a faulting head.
module active_list_commit
   import active_list_commit_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   active_list_commit_if.slave  bus
);
   al_id_t    head;
   al_id_t    tail;
   al_cnt_t   count;
   al_entry_t head_entry;
   al_entry_t head_next_entry;

   logic commit0;
   logic commit1;
   logic flush;
   logic full;

   assign commit0 = entry_commits(head_entry);
   assign commit1 = commit0 & entry_commits(head_next_entry);
   assign flush   = entry_faults(head_entry);
   assign full    = count >= al_cnt_t'(AL_SIZE - 1);

   // Slot1 is only honoured alongside slot0; nothing is accepted while full or flushing.
   logic [1:0]             alloc_en;
   logic [1:0][AL_LOG-1:0] alloc_id;
   assign alloc_en[0] = bus.dispatchValid_i[0] & ~full & ~flush;
   assign alloc_en[1] = alloc_en[0] & bus.dispatchValid_i[1];
   assign alloc_id[0] = tail;
   assign alloc_id[1] = al_id_t'(tail + al_id_t'(1));

   logic [1:0]             retire_en;
   logic [1:0][AL_LOG-1:0] retire_id;
   assign retire_en = {commit1, commit0};
   assign retire_id[0] = head;
   assign retire_id[1] = al_id_t'(head + al_id_t'(1));

   logic [WB_PORTS-1:0][AL_LOG+WB_FLAGS-1:0] ctrl;
   logic [WB_PORTS-1:0]                      wb_valid;
   logic [WB_PORTS-1:0]                      wb_en;
   logic [WB_PORTS-1:0][AL_LOG-1:0]          wb_id;
   logic [WB_PORTS-1:0]                      wb_exc;
   assign ctrl     = {bus.ctrlFU3_i, bus.ctrlFU2_i, bus.ctrlFU1_i, bus.ctrlFU0_i};
   assign wb_valid = {bus.writebkValid3_i, bus.writebkValid2_i,
                      bus.writebkValid1_i, bus.writebkValid0_i};

   always_comb begin
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_en[p]  = wb_valid[p] & ~flush;
         wb_id[p]  = ctrl[p][AL_LOG+WB_FLAGS-1:WB_FLAGS];
         wb_exc[p] = ctrl[p][FLAG_EXCEPTION];
      end
   end

   // Mispredict and conditional flags are informational; recovery comes from the branch path.
   logic flags_unused;
   always_comb begin
      flags_unused = 1'b0;
      for (int p = 0; p < WB_PORTS; p++)
         flags_unused = flags_unused ^ (^ctrl[p][WB_FLAGS-1:1]);
   end

   al_status_bank u_status (
      .clk             (clk),
      .reset           (reset),
      .clear_all       (flush),
      .alloc_en        (alloc_en),
      .alloc_id        (alloc_id),
      .retire_en       (retire_en),
      .retire_id       (retire_id),
      .wb_en           (wb_en),
      .wb_id           (wb_id),
      .wb_exc          (wb_exc),
      .viol_en         (bus.ldViolationPacket_i[AL_LOG] & ~flush),
      .viol_id         (bus.ldViolationPacket_i[AL_LOG-1:0]),
      .head_id         (head),
      .head_entry      (head_entry),
      .head_next_entry (head_next_entry)
   );

   al_cnt_t dispatched;
   al_cnt_t committed;
   assign dispatched = al_cnt_t'(alloc_en[0]) + al_cnt_t'(alloc_en[1]);
   assign committed  = al_cnt_t'(commit0) + al_cnt_t'(commit1);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= al_id_t'(head + al_id_t'(committed));
         tail  <= al_id_t'(tail + al_id_t'(dispatched));
         count <= count + dispatched - committed;
      end
   end

   assign bus.alTail_o       = tail;
   assign bus.alFull_o       = full;
   assign bus.alCount_o      = count;
   assign bus.commitValid0_o = commit0;
   assign bus.commitValid1_o = commit1;
   assign bus.commitAlId0_o  = head;
   assign bus.commitAlId1_o  = al_id_t'(head + al_id_t'(1));
   assign bus.flush_o        = flush;
   assign bus.flushAlId_o    = head;
endmodule

// File: doc/active_list_commit.md
ACTIVE_LIST_COMMIT -- requirements
Module: active_list_commit

Interface
REQ-001 SHALL have port clk, input, 1, clock; reset reset, synchronous, active-high; clock clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port dispatchValid_i, input, 2: per-slot allocate request; slot1 valid only with slot0.
REQ-004 SHALL have port alTail_o, output, AL_LOG: id assigned to dispatch slot0 (slot1 gets alTail_o+1 mod AL_SIZE).
REQ-005 SHALL have port alFull_o, output, 1: asserted when free entries < 2.
REQ-006 SHALL have ports writebkValid0..3_i, input, 1 each: writeback strobes.
REQ-007 SHALL have ports ctrlFU0..3_i, input, AL_LOG+WB_FLAGS each: {alId, flags}; flags[0] exception, flags[1] mispredict, flags[2] conditional, flags[3] reserved.
REQ-008 SHALL have port ldViolationPacket_i, input, AL_LOG+1: {valid(MSB), alId}.
REQ-009 SHALL have ports commitValid0_o/commitValid1_o, output, 1 each; commitAlId0_o/commitAlId1_o, output, AL_LOG each.
REQ-010 SHALL have ports flush_o, output, 1; flushAlId_o, output, AL_LOG: recovery request and offending id.
REQ-011 SHALL have port alCount_o, output, AL_LOG+1: occupied entries.

Function
REQ-012 SHALL keep per-entry bits valid, done, exception, violation in a circular buffer of AL_SIZE=32; head, tail wrap mod AL_SIZE.
REQ-013 SHALL allocate only when alFull_o=0; dispatch while alFull_o=1 ignored, no state change; allocate sets valid, clears done/exception/violation; tail advances by popcount(dispatchValid_i).
REQ-014 SHALL, on writebkValidN_i, set done and OR flags[0] into exception of that entry the next cycle; writeback to an invalid entry ignored.
REQ-015 SHALL, on ldViolationPacket_i valid, set violation of the addressed valid entry; same-cycle writeback and violation to one entry both take effect.
REQ-016 SHALL commit slot0 when head entry valid, done, no exception, no violation; slot1 only if slot0 commits and head+1 meets the same condition; commit outputs combinational from registered state; head advances by commit count next edge.
REQ-017 SHALL, when head entry is valid, done, with exception or violation, assert flush_o one cycle with flushAlId_o=head, no commit that cycle; next edge clears all valid bits, head=tail=0, count=0.
REQ-018 SHALL ignore dispatch and writeback in the flush cycle.
REQ-019 SHALL update alCount_o = count + dispatched - committed each edge; never exceed 32 or underflow.
REQ-020 SHALL treat mispredict flag as informational only (recovery driven by branch path); done still set.
REQ-021 SHALL make newly written done bits visible to commit one cycle after writeback (no same-cycle bypass).

Reset
REQ-022 SHALL on reset clear all entry bits, head, tail, count; commitValid*, flush_o=0, alTail_o=0, alFull_o=0, alCount_o=0, flushAlId_o=0.
REQ-023 SHALL let reset override flush, dispatch and writeback in the same cycle.

Structure
REQ-024 SHALL take AL_SIZE, AL_LOG, WB_PORTS=4, WB_FLAGS=4 and flag bit positions from the shared core package.
REQ-025 SHALL place the per-entry status array in one sub-module al_status_bank (write ports: dispatch x2, writeback x4, violation x1, clear-all; read: head, head+1).

Verification
REQ-026 Dispatch 2 at reset, writeback id1 then id0 -> no commit until both done; then commitValid0/1=1, ids 0,1 same cycle; alCount_o 2->0.
REQ-027 Fill 32 entries -> alFull_o=1 at count 31; extra dispatch ignored, alTail_o unchanged.
REQ-028 Head at 31, entries 31 and 0 done -> commit ids 31,0 in one cycle (wrap).
REQ-029 Writeback id5 with flags[0]=1 at head=5 -> flush_o=1, flushAlId_o=5, no commit; next cycle alCount_o=0, alTail_o=0.
REQ-030 ldViolation {1,3} same cycle as writeback id3 clean, head=3 -> flush with flushAlId_o=3.
REQ-031 Reset asserted during flush cycle with 10 entries -> all outputs 0 next cycle.
